// File: rtl/gpmc_master.sv
// Single-word GPMC sync initiator: request -> ADDR / WDATA or RWAIT*RD_WAIT + RSAMPLE / END phases.
// Latency: 6 clk (write) or 6+2*RD_WAIT clk (read) from accept edge to req_ready; one IDLE cycle between cycles.
// Backpressure: req_ready only in IDLE, no queueing; requests seen while busy are ignored.
module gpmc_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WAIT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_done,
    output logic                  busy,
    inout  wire  [DATA_WIDTH-1:0] gpmc_ad,
    output logic                  gpmc_advn,
    output logic                  gpmc_csn1,
    output logic                  gpmc_wein,
    output logic                  gpmc_oen,
    output logic                  gpmc_clk
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_RWAIT, S_RSAMPLE, S_END
    } state_t;

    localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t                state, state_nxt;
    logic                  half, half_nxt;
    logic [3:0]            wcnt, wcnt_nxt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  accept;

    logic                  ad_oe, ad_oe_nxt;
    logic [DATA_WIDTH-1:0] ad_out, ad_out_nxt;
    logic [ADDR_WIDTH-1:0] addr_src;
    logic                  csn_nxt, advn_nxt, wein_nxt, oen_nxt, gclk_nxt;
    logic                  first_end;

    assign accept  = req_valid & req_ready;
    assign gpmc_ad = ad_oe ? ad_out : {DATA_WIDTH{1'bz}};

    // half=0 is the gpmc_clk-low cycle of a phase, half=1 the high cycle.
    always_comb begin
        state_nxt = state;
        half_nxt  = ~half;
        wcnt_nxt  = wcnt;
        case (state)
            S_IDLE: begin
                half_nxt = 1'b0;
                if (accept) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (half) begin
                    wcnt_nxt = 4'd0;
                    if (we_q)             state_nxt = S_WDATA;
                    else if (RD_WAIT > 0) state_nxt = S_RWAIT;
                    else                  state_nxt = S_RSAMPLE;
                end
            end
            S_WDATA: begin
                if (half) state_nxt = S_END;
            end
            S_RWAIT: begin
                if (half) begin
                    if (wcnt == WAIT_LAST) begin
                        wcnt_nxt  = 4'd0;
                        state_nxt = S_RSAMPLE;
                    end else begin
                        wcnt_nxt = wcnt + 4'd1;
                    end
                end
            end
            S_RSAMPLE: begin
                if (half) state_nxt = S_END;
            end
            S_END: begin
                if (half) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                half_nxt  = 1'b0;
            end
        endcase
    end

    // Bus pins are decoded from the next state so every output leaves a flop.
    always_comb begin
        addr_src   = (state == S_IDLE) ? req_addr : addr_q;
        csn_nxt    = !(state_nxt inside {S_ADDR, S_WDATA, S_RWAIT, S_RSAMPLE});
        advn_nxt   = (state_nxt != S_ADDR);
        wein_nxt   = (state_nxt != S_WDATA);
        oen_nxt    = !(state_nxt inside {S_RWAIT, S_RSAMPLE});
        gclk_nxt   = (state_nxt != S_IDLE) && half_nxt;
        ad_oe_nxt  = (state_nxt inside {S_ADDR, S_WDATA});
        ad_out_nxt = '0;
        if (state_nxt == S_ADDR)
            ad_out_nxt[ADDR_WIDTH-1:0] = addr_src;
        else if (state_nxt == S_WDATA)
            ad_out_nxt = wdata_q;
        first_end  = (state_nxt == S_END) && (state != S_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            half      <= 1'b0;
            wcnt      <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            rsp_rdata <= '0;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            gpmc_csn1 <= 1'b1;
            gpmc_advn <= 1'b1;
            gpmc_wein <= 1'b1;
            gpmc_oen  <= 1'b1;
            gpmc_clk  <= 1'b0;
        end else begin
            state     <= state_nxt;
            half      <= half_nxt;
            wcnt      <= wcnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            req_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            rsp_valid <= first_end && !we_q;
            wr_done   <= first_end && we_q;
            if (state == S_RSAMPLE && half)
                rsp_rdata <= gpmc_ad;
            ad_oe     <= ad_oe_nxt;
            ad_out    <= ad_out_nxt;
            gpmc_csn1 <= csn_nxt;
            gpmc_advn <= advn_nxt;
            gpmc_wein <= wein_nxt;
            gpmc_oen  <= oen_nxt;
            gpmc_clk  <= gclk_nxt;
        end
    end

endmodule
